axi_lite_regfile: RTL and testbench
===================================

// Module: axi_lite_regfile
// PURPOSE
//  AXI-Lite responder: terminates one axi_lite_channel (slave modport) in a bank of NUM_REGS
//  DATA_WIDTH-bit control/status registers. Sits behind the interconnect at each peripheral's
//  register window. Read-write registers drive fabric logic; read-only slots return live status.
//  Write and read paths are independent and run concurrently.
// PARAMETERS
//  ADDR_WIDTH  48  address width; must match the attached channel
//  DATA_WIDTH  64  register/data width; 32 or 64, must match the channel
//  NUM_REGS    16  register count, >=1; window = NUM_REGS*DATA_WIDTH/8 bytes from BASE_ADDR
//  BASE_ADDR   0   byte base of the window; aligned to the window size rounded up to pow2
//  RO_MASK     0   NUM_REGS-bit mask; bit i set = slot i is read-only status
//  RST_VAL     0   reset value of every read-write register
// PORTS
//  clk           in   1                    clock
//  rstn          in   1                    asynchronous active-low reset
//  slave         io   axi_lite_channel.slave  AXI-Lite port (same clk/rstn)
//  reg_q         out  NUM_REGS x DATA_WIDTH  current register contents (RO slots read 0)
//  reg_wr        out  NUM_REGS             1-cycle pulse on commit of a write to slot i
//  sts_i         in   NUM_REGS x DATA_WIDTH  status values returned for RO slots
// BEHAVIOUR
//  Decode: off = addr - BASE_ADDR; idx = off >> log2(DATA_WIDTH/8); low offset bits ignored.
//   off outside window -> DECERR; write to RO slot -> SLVERR, no update; else OKAY.
//  Write path: one-entry AW holding reg and one-entry W holding reg, filled independently.
//   aw_ready = !aw_full, w_ready = !w_full (combinational from registered flags).
//   When aw_full && w_full && !b_valid: commit in that cycle (byte lanes per w_strb, zero strb =
//   no change but OKAY), pulse reg_wr[idx] next cycle, clear both holds, set b_valid/b_resp.
//   b_valid held until b_ready; hold regs may refill while B pending (1 write in flight).
//   AW then W, W then AW, and same-cycle AW+W all give b_valid 1 cycle after the later handshake.
//  Read path: ar_ready = !r_valid. On AR handshake, r_data/r_resp registered, r_valid next
//   cycle, held stable until r_ready. Latency 1 cycle; throughput 1 per 2 cycles.
//   DECERR reads return r_data 0; RO slots return sts_i sampled at AR handshake.
//  Same-cycle commit and AR to same slot: read returns pre-write value.
//  Reset (async assert, sync release): reg_q = RST_VAL, holds empty, b_valid=r_valid=0,
//   b_resp=r_resp=OKAY, r_data=0, reg_wr=0; aw/w/ar_ready=1 after release. Reset mid-
//   transaction drops it silently; the master is reset by the same rstn.
//  Outputs never depend combinationally on *_valid inputs (no valid->ready paths).
// CONFIGURATION
//  AXI_LITE_REGFILE_PROT_CHECK_EN defined: AW/AR with prot privileged bit (bit 0) clear get
//   SLVERR (writes not committed, no reg_wr; reads return 0). Decode errors still take DECERR
//   priority. Undefined: prot ignored, all accesses unprivileged-legal.
// STRUCTURE
//  axi_common package: resp_t/prot_t and RESP_OKAY/RESP_SLVERR/RESP_DECERR (existing); add
//   function lite_decode(addr, base, nregs) returning {hit, idx} for reuse by other responders.
//  One sub-module: axi_lite_hold - one-entry valid/ready holding register (payload param),
//   instantiated for AW and W. Read path and register array inline.
// TESTING
//  1 AW(0x08)+W(0xDEAD_BEEF, strb 0xFF) same cycle -> b_valid next cycle OKAY, reg_q[1]=
//    0xDEADBEEF, reg_wr[1] single pulse.
//  2 W 0x1122334455667788 strb 0x0F, AW(0x10) 3 cycles later -> reg_q[2] low 4 bytes only
//    changed; B 1 cycle after AW; b_ready low 5 cycles -> b_valid/b_resp stable, new AW accepted.
//  3 AR 0x1000 (outside 16x8 window) -> DECERR, r_data 0; write there -> DECERR, no reg_wr.
//  4 RO_MASK bit 3, sts_i[3]=0xA5: AR 0x18 -> OKAY, 0xA5; write 0x18 -> SLVERR, no change.
//  5 Commit to slot 0 and AR 0x00 same cycle -> old value; next AR returns new value.
//  6 rstn low while B and R pending -> all valids 0, reg_q=RST_VAL; PROT_CHECK_EN build:
//    AR prot=0 -> SLVERR, r_data 0.

Source files
------------

// File: rtl/axi_common_pkg.sv
// Shared AXI types and response codes, plus the register-window decode helper
// reused by AXI-Lite responders.
package axi_common;

   typedef logic [1:0] resp_t;
   typedef logic [2:0] prot_t;

   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_SLVERR = 2'b10;
   localparam resp_t RESP_DECERR = 2'b11;

   typedef struct packed {
      logic        hit;
      logic [31:0] idx;
   } lite_dec_t;

   // An address below base wraps to a huge offset, so one compare covers both window ends.
   function automatic lite_dec_t lite_decode(input logic [63:0] addr,
                                             input logic [63:0] base,
                                             input int unsigned nregs,
                                             input int unsigned lsb);
      logic [63:0] off;
      logic [63:0] word;
      lite_dec_t   dec;
      off     = addr - base;
      word    = off >> lsb;
      dec.hit = (word < 64'(nregs));
      dec.idx = word[31:0];
      return dec;
   endfunction

endpackage

// File: rtl/axi_lite_channel.sv
// AXI-Lite channel bundle: five handshake channels with master and slave views.
interface axi_lite_channel
   import axi_common::*;
#(
   parameter int unsigned ADDR_WIDTH = 48,
   parameter int unsigned DATA_WIDTH = 64
);
   logic                      aw_valid;
   logic                      aw_ready;
   logic [ADDR_WIDTH-1:0]     aw_addr;
   prot_t                     aw_prot;
   logic                      w_valid;
   logic                      w_ready;
   logic [DATA_WIDTH-1:0]     w_data;
   logic [DATA_WIDTH/8-1:0]   w_strb;
   logic                      b_valid;
   logic                      b_ready;
   resp_t                     b_resp;
   logic                      ar_valid;
   logic                      ar_ready;
   logic [ADDR_WIDTH-1:0]     ar_addr;
   prot_t                     ar_prot;
   logic                      r_valid;
   logic                      r_ready;
   logic [DATA_WIDTH-1:0]     r_data;
   resp_t                     r_resp;

   modport master (
      output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
             ar_valid, ar_addr, ar_prot, r_ready,
      input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
   );

   modport slave (
      input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
             ar_valid, ar_addr, ar_prot, r_ready,
      output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
   );
endinterface

// File: rtl/axi_lite_hold.sv
// One-entry valid/ready holding register; ready depends only on the registered full flag.
module axi_lite_hold #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             clear,
   output logic             full,
   output logic [WIDTH-1:0] data
);
   logic             full_reg;
   logic [WIDTH-1:0] data_reg;

   // clear only arrives while full, so it never collides with a fill.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         full_reg <= 1'b0;
         data_reg <= '0;
      end else if (clear) begin
         full_reg <= 1'b0;
      end else if (in_valid && !full_reg) begin
         full_reg <= 1'b1;
         data_reg <= in_data;
      end
   end

   assign in_ready = !full_reg;
   assign full     = full_reg;
   assign data     = data_reg;
endmodule

// File: rtl/axi_lite_regfile.sv
// AXI-Lite register bank: NUM_REGS read-write or read-only status slots behind one window.
// Optional feature macro AXI_LITE_REGFILE_PROT_CHECK_EN: unprivileged accesses get SLVERR.
module axi_lite_regfile
   import axi_common::*;
#(
   parameter int unsigned           ADDR_WIDTH = 48,
   parameter int unsigned           DATA_WIDTH = 64,
   parameter int unsigned           NUM_REGS   = 16,
   parameter logic [63:0]           BASE_ADDR  = 64'h0,
   parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
   parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
   input  logic                                 clk,
   input  logic                                 rstn,
   axi_lite_channel.slave                       slave,
   output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  reg_q,
   output logic [NUM_REGS-1:0]                  reg_wr,
   input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  sts_i
);
   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned LSB    = $clog2(STRB_W);
   localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int unsigned AWP_W  = ADDR_WIDTH + 3;
   localparam int unsigned WP_W   = DATA_WIDTH + STRB_W;

   logic                   aw_full;
   logic                   w_full;
   logic                   commit;
   logic                   wr_en;
   logic [AWP_W-1:0]       aw_hold_data;
   logic [WP_W-1:0]        w_hold_data;
   logic [ADDR_WIDTH-1:0]  aw_addr_hold;
   prot_t                  aw_prot_hold;
   logic [DATA_WIDTH-1:0]  w_data_hold;
   logic [STRB_W-1:0]      w_strb_hold;

   logic                   b_valid_reg;
   resp_t                  b_resp_reg;
   logic                   r_valid_reg;
   resp_t                  r_resp_reg;
   logic [DATA_WIDTH-1:0]  r_data_reg;
   logic [NUM_REGS-1:0]    reg_wr_reg;

   lite_dec_t              wr_dec;
   lite_dec_t              rd_dec;
   logic [IDX_W-1:0]       wr_idx;
   logic [IDX_W-1:0]       rd_idx;
   resp_t                  wr_resp;
   resp_t                  rd_resp;
   logic [DATA_WIDTH-1:0]  rd_data_next;
   logic                   wr_prot_err;
   logic                   rd_prot_err;
   logic                   unused_ok;

   axi_lite_hold #(.WIDTH(AWP_W)) u_aw_hold (
      .clk      (clk),
      .rstn     (rstn),
      .in_valid (slave.aw_valid),
      .in_ready (slave.aw_ready),
      .in_data  ({slave.aw_prot, slave.aw_addr}),
      .clear    (commit),
      .full     (aw_full),
      .data     (aw_hold_data)
   );

   axi_lite_hold #(.WIDTH(WP_W)) u_w_hold (
      .clk      (clk),
      .rstn     (rstn),
      .in_valid (slave.w_valid),
      .in_ready (slave.w_ready),
      .in_data  ({slave.w_strb, slave.w_data}),
      .clear    (commit),
      .full     (w_full),
      .data     (w_hold_data)
   );

   assign aw_prot_hold = aw_hold_data[AWP_W-1 -: 3];
   assign aw_addr_hold = aw_hold_data[ADDR_WIDTH-1:0];
   assign w_strb_hold  = w_hold_data[WP_W-1 -: STRB_W];
   assign w_data_hold  = w_hold_data[DATA_WIDTH-1:0];

`ifdef AXI_LITE_REGFILE_PROT_CHECK_EN
   assign wr_prot_err = !aw_prot_hold[0];
   assign rd_prot_err = !slave.ar_prot[0];
`else
   assign wr_prot_err = 1'b0;
   assign rd_prot_err = 1'b0;
`endif

   always_comb begin
      wr_dec = lite_decode(64'(aw_addr_hold), BASE_ADDR, NUM_REGS, LSB);
      wr_idx = wr_dec.idx[IDX_W-1:0];
      if (!wr_dec.hit)
         wr_resp = RESP_DECERR;
      else if (wr_prot_err || RO_MASK[wr_idx])
         wr_resp = RESP_SLVERR;
      else
         wr_resp = RESP_OKAY;
   end

   // Only one write in flight: the next commit waits until the pending B is taken.
   assign commit = aw_full && w_full && !b_valid_reg;
   assign wr_en  = commit && (wr_resp == RESP_OKAY);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         if (RO_MASK[gi]) begin : g_ro
            assign reg_q[gi] = '0;
         end else begin : g_rw
            logic [DATA_WIDTH-1:0] q_reg;
            always_ff @(posedge clk or negedge rstn) begin
               if (!rstn) begin
                  q_reg <= RST_VAL;
               end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                  for (int b = 0; b < STRB_W; b++) begin
                     if (w_strb_hold[b])
                        q_reg[8*b +: 8] <= w_data_hold[8*b +: 8];
                  end
               end
            end
            assign reg_q[gi] = q_reg;
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         reg_wr_reg  <= '0;
         b_valid_reg <= 1'b0;
         b_resp_reg  <= RESP_OKAY;
      end else begin
         reg_wr_reg <= '0;
         if (wr_en)
            reg_wr_reg[wr_idx] <= 1'b1;
         if (commit) begin
            b_valid_reg <= 1'b1;
            b_resp_reg  <= wr_resp;
         end else if (slave.b_ready) begin
            b_valid_reg <= 1'b0;
         end
      end
   end

   always_comb begin
      rd_dec       = lite_decode(64'(slave.ar_addr), BASE_ADDR, NUM_REGS, LSB);
      rd_idx       = rd_dec.idx[IDX_W-1:0];
      rd_data_next = '0;
      if (!rd_dec.hit) begin
         rd_resp = RESP_DECERR;
      end else if (rd_prot_err) begin
         rd_resp = RESP_SLVERR;
      end else begin
         rd_resp      = RESP_OKAY;
         rd_data_next = RO_MASK[rd_idx] ? sts_i[rd_idx] : reg_q[rd_idx];
      end
   end

   // reg_q is sampled before this edge's commit lands, so a colliding read sees the old value.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_valid_reg <= 1'b0;
         r_resp_reg  <= RESP_OKAY;
         r_data_reg  <= '0;
      end else if (slave.ar_valid && !r_valid_reg) begin
         r_valid_reg <= 1'b1;
         r_resp_reg  <= rd_resp;
         r_data_reg  <= rd_data_next;
      end else if (slave.r_ready) begin
         r_valid_reg <= 1'b0;
      end
   end

   assign slave.b_valid  = b_valid_reg;
   assign slave.b_resp   = b_resp_reg;
   assign slave.ar_ready = !r_valid_reg;
   assign slave.r_valid  = r_valid_reg;
   assign slave.r_resp   = r_resp_reg;
   assign slave.r_data   = r_data_reg;
   assign reg_wr         = reg_wr_reg;

   assign unused_ok = ^{aw_prot_hold, slave.ar_prot, wr_dec.idx, rd_dec.idx};
endmodule

// File: tb/tb_axi_lite_regfile.sv
// Scoreboard bench for axi_lite_regfile: drivers push expected B/R responses from a
// byte-level register model, a negedge monitor pops and compares on each handshake.
module tb_axi_lite_regfile;
   import axi_common::*;

   localparam int NR = 16;
   localparam int DW = 64;
   localparam int AW = 48;
   localparam logic [NR-1:0] RO   = 16'h0008;
   localparam logic [DW-1:0] RSTV = 64'hC0DE_0000_0000_5A5A;

   typedef struct packed {
      resp_t         resp;
      logic [DW-1:0] data;
   } rsp_t;

   logic clk  = 1'b0;
   logic rstn = 1'b1;
   always #5 clk = ~clk;

   axi_lite_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
   logic [NR-1:0][DW-1:0] reg_q;
   logic [NR-1:0][DW-1:0] sts;
   logic [NR-1:0]         reg_wr;

   axi_lite_regfile #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .NUM_REGS   (NR),
      .BASE_ADDR  (64'h0),
      .RO_MASK    (RO),
      .RST_VAL    (RSTV)
   ) dut (
      .clk    (clk),
      .rstn   (rstn),
      .slave  (bus),
      .reg_q  (reg_q),
      .reg_wr (reg_wr),
      .sts_i  (sts)
   );

   int            total = 0;
   int            bad   = 0;
   logic [DW-1:0] model [NR];
   int            exp_wr [NR];
   int            got_wr [NR];
   rsp_t          exp_b [$];
   rsp_t          exp_r [$];

   function automatic void check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endfunction

   function automatic logic prot_bad(input logic [2:0] p);
`ifdef AXI_LITE_REGFILE_PROT_CHECK_EN
      return !p[0];
`else
      return 1'b0;
`endif
   endfunction

   // Window is 16 slots x 8 bytes from address 0; slot = byte address / 8.
   function automatic resp_t model_resp(input logic [AW-1:0] a, input logic [2:0] p, input bit is_wr);
      int slot;
      if (a >= AW'(NR * 8)) return RESP_DECERR;
      slot = int'(a / 8);
      if (prot_bad(p)) return RESP_SLVERR;
      if (is_wr && RO[slot]) return RESP_SLVERR;
      return RESP_OKAY;
   endfunction

   function automatic void issue_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                       input logic [7:0] s, input logic [2:0] p);
      rsp_t e;
      int   slot;
      e.resp = model_resp(a, p, 1'b1);
      e.data = '0;
      exp_b.push_back(e);
      if (e.resp == RESP_OKAY) begin
         slot = int'(a / 8);
         for (int b = 0; b < 8; b++)
            if (s[b]) model[slot][8*b +: 8] = d[8*b +: 8];
         exp_wr[slot]++;
      end
   endfunction

   function automatic void issue_read(input logic [AW-1:0] a, input logic [2:0] p);
      rsp_t e;
      int   slot;
      e.resp = model_resp(a, p, 1'b0);
      e.data = '0;
      if (e.resp == RESP_OKAY) begin
         slot   = int'(a / 8);
         e.data = RO[slot] ? sts[slot] : model[slot];
      end
      exp_r.push_back(e);
   endfunction

   always @(negedge clk) begin : monitor
      rsp_t e;
      for (int i = 0; i < NR; i++)
         if (reg_wr[i]) got_wr[i]++;
      if (rstn && bus.b_valid && bus.b_ready) begin
         if (exp_b.size() == 0) begin
            check("b_unexpected", 64'(bus.b_valid), 64'(0));
         end else begin
            e = exp_b.pop_front();
            check("b_resp", 64'(bus.b_resp), 64'(e.resp));
            $display("B  resp=%0d", bus.b_resp);
         end
      end
      if (rstn && bus.r_valid && bus.r_ready) begin
         if (exp_r.size() == 0) begin
            check("r_unexpected", 64'(bus.r_valid), 64'(0));
         end else begin
            e = exp_r.pop_front();
            check("r_resp", 64'(bus.r_resp), 64'(e.resp));
            check("r_data", bus.r_data, e.data);
            $display("R  resp=%0d data=%h", bus.r_resp, bus.r_data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_aw(input logic [AW-1:0] a, input logic [2:0] p, input int dly);
      bit hs = 1'b0;
      repeat (dly) tick();
      bus.aw_addr  = a;
      bus.aw_prot  = p;
      bus.aw_valid = 1'b1;
      for (int n = 0; n < 20 && !hs; n++) begin
         @(negedge clk);
         hs = bus.aw_ready;
         tick();
      end
      bus.aw_valid = 1'b0;
      check("aw_accept", 64'(hs), 64'(1));
   endtask

   task automatic send_w(input logic [DW-1:0] d, input logic [7:0] s, input int dly);
      bit hs = 1'b0;
      repeat (dly) tick();
      bus.w_data  = d;
      bus.w_strb  = s;
      bus.w_valid = 1'b1;
      for (int n = 0; n < 20 && !hs; n++) begin
         @(negedge clk);
         hs = bus.w_ready;
         tick();
      end
      bus.w_valid = 1'b0;
      check("w_accept", 64'(hs), 64'(1));
   endtask

   task automatic send_ar(input logic [AW-1:0] a, input logic [2:0] p, input int dly);
      bit hs = 1'b0;
      repeat (dly) tick();
      bus.ar_addr  = a;
      bus.ar_prot  = p;
      bus.ar_valid = 1'b1;
      for (int n = 0; n < 20 && !hs; n++) begin
         @(negedge clk);
         hs = bus.ar_ready;
         tick();
      end
      bus.ar_valid = 1'b0;
      check("ar_accept", 64'(hs), 64'(1));
   endtask

   task automatic wait_b(input int dly);
      bit          hs = 1'b0;
      logic [1:0]  r0;
      r0 = bus.b_resp;
      for (int i = 0; i < dly; i++) begin
         @(negedge clk);
         check("b_hold_valid", 64'(bus.b_valid), 64'(1));
         check("b_hold_resp", 64'(bus.b_resp), 64'(r0));
         tick();
      end
      bus.b_ready = 1'b1;
      for (int n = 0; n < 20 && !hs; n++) begin
         @(negedge clk);
         hs = bus.b_valid;
         tick();
      end
      bus.b_ready = 1'b0;
      check("b_seen", 64'(hs), 64'(1));
   endtask

   task automatic wait_r(input int dly);
      bit            hs = 1'b0;
      logic [DW-1:0] d0;
      d0 = bus.r_data;
      for (int i = 0; i < dly; i++) begin
         @(negedge clk);
         check("r_hold_valid", 64'(bus.r_valid), 64'(1));
         check("r_hold_data", bus.r_data, d0);
         tick();
      end
      bus.r_ready = 1'b1;
      for (int n = 0; n < 20 && !hs; n++) begin
         @(negedge clk);
         hs = bus.r_valid;
         tick();
      end
      bus.r_ready = 1'b0;
      check("r_seen", 64'(hs), 64'(1));
   endtask

   task automatic check_state();
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
         check($sformatf("reg_q[%0d]", i), reg_q[i], RO[i] ? 64'(0) : model[i]);
         check($sformatf("reg_wr_count[%0d]", i), 64'(got_wr[i]), 64'(exp_wr[i]));
      end
      tick();
   endtask

   task automatic write_txn(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [7:0] s,
                            input logic [2:0] p, input int aw_d, input int w_d, input int b_d);
      issue_write(a, d, s, p);
      $display("WR addr=%h data=%h strb=%h prot=%0d", a, d, s, p);
      fork
         send_aw(a, p, aw_d);
         send_w(d, s, w_d);
      join
      check("b_not_early", 64'(bus.b_valid), 64'(0));
      tick();
      check("b_latency", 64'(bus.b_valid), 64'(1));
      wait_b(b_d);
      check_state();
   endtask

   task automatic read_txn(input logic [AW-1:0] a, input logic [2:0] p, input int ar_d, input int r_d);
      issue_read(a, p);
      $display("RD addr=%h prot=%0d", a, p);
      send_ar(a, p, ar_d);
      check("r_latency", 64'(bus.r_valid), 64'(1));
      wait_r(r_d);
   endtask

   task automatic do_reset();
      bus.aw_valid = 1'b0;
      bus.w_valid  = 1'b0;
      bus.ar_valid = 1'b0;
      bus.b_ready  = 1'b0;
      bus.r_ready  = 1'b0;
      rstn = 1'b0;
      #2;
      check("rst_b_valid", 64'(bus.b_valid), 64'(0));
      check("rst_r_valid", 64'(bus.r_valid), 64'(0));
      check("rst_b_resp", 64'(bus.b_resp), 64'(RESP_OKAY));
      check("rst_r_resp", 64'(bus.r_resp), 64'(RESP_OKAY));
      check("rst_r_data", bus.r_data, 64'(0));
      check("rst_reg_wr", 64'(reg_wr), 64'(0));
      for (int i = 0; i < NR; i++) begin
         model[i] = RSTV;
         check($sformatf("rst_reg_q[%0d]", i), reg_q[i], RO[i] ? 64'(0) : RSTV);
      end
      exp_b.delete();
      exp_r.delete();
      tick();
      tick();
      rstn = 1'b1;
      tick();
      check("rst_aw_ready", 64'(bus.aw_ready), 64'(1));
      check("rst_w_ready", 64'(bus.w_ready), 64'(1));
      check("rst_ar_ready", 64'(bus.ar_ready), 64'(1));
   endtask

   initial begin : stim
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [7:0]    s;
      logic [2:0]    p;
      logic [DW-1:0] old0;
      rsp_t          e;

      bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.ar_valid = 1'b0;
      bus.b_ready  = 1'b0; bus.r_ready = 1'b0;
      bus.aw_addr  = '0;   bus.aw_prot = 3'b001; bus.ar_addr = '0; bus.ar_prot = 3'b001;
      bus.w_data   = '0;   bus.w_strb  = '0;
      for (int i = 0; i < NR; i++) begin
         sts[i]    = {$urandom, $urandom};
         exp_wr[i] = 0;
         got_wr[i] = 0;
      end
      sts[3] = 64'hA5;
      #3;
      do_reset();

      // Same-cycle AW+W, full write
      write_txn(48'h08, 64'hDEAD_BEEF, 8'hFF, 3'b001, 0, 0, 0);

      // W first, AW three cycles later, low lanes only, B held for 5 cycles
      write_txn(48'h10, 64'h1122_3344_5566_7788, 8'h0F, 3'b001, 3, 0, 5);

      // New AW accepted while the previous B is still pending
      issue_write(48'h28, 64'h0F0F_0000_1234_5678, 8'hFF, 3'b001);
      fork
         send_aw(48'h28, 3'b001, 0);
         send_w(64'h0F0F_0000_1234_5678, 8'hFF, 2);
      join
      tick();
      check("b_pend_valid", 64'(bus.b_valid), 64'(1));
      issue_write(48'h30, 64'h7777_8888_9999_AAAA, 8'hF0, 3'b001);
      send_aw(48'h30, 3'b001, 0);
      wait_b(3);
      send_w(64'h7777_8888_9999_AAAA, 8'hF0, 0);
      check("b2_not_early", 64'(bus.b_valid), 64'(0));
      tick();
      check("b2_latency", 64'(bus.b_valid), 64'(1));
      wait_b(0);
      check_state();

      // Outside the window
      read_txn(48'h1000, 3'b001, 0, 0);
      write_txn(48'h1000, 64'h1, 8'hFF, 3'b001, 0, 1, 0);

      // Read-only status slot
      read_txn(48'h18, 3'b001, 0, 2);
      write_txn(48'h18, 64'hFFFF, 8'hFF, 3'b001, 1, 0, 0);

      // Zero strobe: OKAY, data unchanged
      write_txn(48'h08, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 3'b001, 0, 0, 1);

      // Commit and AR to slot 0 in the same cycle: read returns the old value
      old0   = model[0];
      e.resp = RESP_OKAY;
      e.data = old0;
      exp_r.push_back(e);
      issue_write(48'h00, 64'hCAFE_F00D_0BAD_BEEF, 8'hFF, 3'b001);
      $display("WR+RD same cycle addr=0");
      bus.aw_addr = 48'h00; bus.aw_prot = 3'b001; bus.aw_valid = 1'b1;
      bus.w_data  = 64'hCAFE_F00D_0BAD_BEEF; bus.w_strb = 8'hFF; bus.w_valid = 1'b1;
      tick();
      bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
      bus.ar_addr  = 48'h00; bus.ar_prot = 3'b001; bus.ar_valid = 1'b1;
      tick();
      bus.ar_valid = 1'b0;
      check("coll_b_valid", 64'(bus.b_valid), 64'(1));
      check("coll_r_valid", 64'(bus.r_valid), 64'(1));
      wait_b(0);
      wait_r(0);
      check_state();
      read_txn(48'h00, 3'b001, 0, 0);

      // Randomized traffic
      for (int k = 0; k < 80; k++) begin
         if ($urandom_range(0, 15) == 0)
            a = 48'h2000 + AW'($urandom_range(0, 255));
         else
            a = AW'($urandom_range(0, 19) * 8 + $urandom_range(0, 7));
         d = {$urandom, $urandom};
         s = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
`ifdef AXI_LITE_REGFILE_PROT_CHECK_EN
         p = 3'($urandom_range(0, 7));
`else
         p = 3'($urandom_range(0, 7));
`endif
         if ($urandom_range(0, 3) == 0) sts[3] = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 0)
            write_txn(a, d, s, p, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         else
            read_txn(a, p, $urandom_range(0, 2), $urandom_range(0, 3));
      end

`ifdef AXI_LITE_REGFILE_PROT_CHECK_EN
      read_txn(48'h08, 3'b000, 0, 0);
      write_txn(48'h08, 64'h5555, 8'hFF, 3'b010, 0, 0, 0);
      read_txn(48'h1000, 3'b000, 0, 0);
`endif

      // Reset with both B and R pending
      issue_write(48'h20, 64'h0123_4567_89AB_CDEF, 8'hFF, 3'b001);
      fork
         send_aw(48'h20, 3'b001, 0);
         send_w(64'h0123_4567_89AB_CDEF, 8'hFF, 0);
      join
      issue_read(48'h28, 3'b001);
      send_ar(48'h28, 3'b001, 0);
      tick();
      tick();
      check("pre_rst_b_valid", 64'(bus.b_valid), 64'(1));
      check("pre_rst_r_valid", 64'(bus.r_valid), 64'(1));
      do_reset();
      check_state();
      read_txn(48'h20, 3'b001, 0, 0);

      tick();
      check("b_queue_empty", 64'(exp_b.size()), 64'(0));
      check("r_queue_empty", 64'(exp_r.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog expired");
   end
endmodule
